// File: rtl/sram_pkg.sv
// Shared types and constants for the asynchronous SRAM controller.
// SRAM_CTRL_TURNAROUND_EN adds the S_TURN dead-bus state after each write.
package sram_pkg;

    localparam int ADDR_W_DEF = 20;
    localparam int DATA_W_DEF = 8;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR_SETUP = 3'd1,
        S_WR_PULSE = 3'd2,
        S_WR_HOLD  = 3'd3,
        S_RD       = 3'd4
`ifdef SRAM_CTRL_TURNAROUND_EN
        ,
        S_TURN     = 3'd5
`endif
    } state_e;

    // Counter must hold max(N)-1 with one spare bit of headroom.
    function automatic int wait_cnt_w(input int wr_cycles, input int rd_cycles);
        int m;
        m = (wr_cycles > rd_cycles) ? wr_cycles : rd_cycles;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/sram_controller_if.sv
// Client request bus. Handshake: a request is taken on a rising edge where
// ready=1 and mem=1; rw/addr/data2ram are qualified by mem, mem with ready=0 is dropped.
interface sram_controller_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 8
);
    logic              mem;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data2ram;
    logic              ready;
    logic [DATA_W-1:0] data2fpga;

    modport master (
        output mem, rw, addr, data2ram,
        input  ready, data2fpga
    );

    modport slave (
        input  mem, rw, addr, data2ram,
        output ready, data2fpga
    );
endinterface

// File: rtl/sram_wait_timer.sv
// Down-counter shared by the write-pulse and read states: load N-1 on entry,
// done while the count sits at zero.
module sram_wait_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);
endmodule

// File: rtl/sram_controller.sv
// Single-beat responder for a 1M x 8 asynchronous SRAM; all pins registered.
// Optional macro SRAM_CTRL_TURNAROUND_EN inserts one dead-bus cycle after writes.
module sram_controller
    import sram_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int WR_CYCLES = 1,
    parameter int RD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    sram_controller_if.slave  req,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [DATA_W-1:0] sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_i
);
    localparam int CNT_W = wait_cnt_w(WR_CYCLES, RD_CYCLES);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYCLES - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dq_o_q, dq_o_d;
    logic [DATA_W-1:0] data2fpga_q, data2fpga_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              dq_oe_q, dq_oe_d;
    logic              tmr_load;
    logic [CNT_W-1:0]  tmr_val;
    logic              tmr_done;

    sram_wait_timer #(.CNT_W(CNT_W)) u_wait_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        dq_o_d      = dq_o_q;
        data2fpga_d = data2fpga_q;
        tmr_load    = 1'b0;
        tmr_val     = '0;

        case (state_q)
            S_IDLE: begin
                if (req.mem) begin
                    addr_d = req.addr;
                    if (req.rw == RW_READ) begin
                        state_d  = S_RD;
                        tmr_load = 1'b1;
                        tmr_val  = RD_LOAD;
                    end else begin
                        state_d = S_WR_SETUP;
                        dq_o_d  = req.data2ram;
                    end
                end
            end
            S_WR_SETUP: begin
                state_d  = S_WR_PULSE;
                tmr_load = 1'b1;
                tmr_val  = WR_LOAD;
            end
            S_WR_PULSE: begin
                if (tmr_done) state_d = S_WR_HOLD;
            end
            S_WR_HOLD: begin
`ifdef SRAM_CTRL_TURNAROUND_EN
                state_d = S_TURN;
`else
                state_d = S_IDLE;
`endif
            end
            S_RD: begin
                if (tmr_done) begin
                    data2fpga_d = sram_dq_i;
                    state_d     = S_IDLE;
                end
            end
`ifdef SRAM_CTRL_TURNAROUND_EN
            S_TURN: state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase

        // Pins are decoded from the next state so they change on the same edge as the state.
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        dq_oe_d = 1'b0;
        case (state_d)
            S_WR_SETUP: begin
                ce_n_d  = 1'b0;
                dq_oe_d = 1'b1;
            end
            S_WR_PULSE: begin
                ce_n_d  = 1'b0;
                we_n_d  = 1'b0;
                dq_oe_d = 1'b1;
            end
            S_WR_HOLD: begin
                ce_n_d  = 1'b0;
                dq_oe_d = 1'b1;
            end
            S_RD: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            dq_o_q      <= '0;
            data2fpga_q <= '0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            dq_oe_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            dq_o_q      <= dq_o_d;
            data2fpga_q <= data2fpga_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            dq_oe_q     <= dq_oe_d;
        end
    end

    assign req.ready     = (state_q == S_IDLE);
    assign req.data2fpga = data2fpga_q;
    assign sram_addr     = addr_q;
    assign sram_ce_n     = ce_n_q;
    assign sram_oe_n     = oe_n_q;
    assign sram_we_n     = we_n_q;
    assign sram_dq_o     = dq_o_q;
    assign sram_dq_oe    = dq_oe_q;
endmodule
